// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and index helper for the mutex arbiter family.
package arb_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  function automatic int onehot2idx(input logic [31:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < 32; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational picker: first set bit at or above ptr with wrap (mode=1), or lowest set bit (mode=0).
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when the winner is consumed.
module arb_rr_pick #(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               mode,
  output logic [NUM_REQ-1:0] win,
  output logic [IDX_W-1:0]   win_idx,
  output logic               any
);
  import arb_pkg::*;

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] sel;
  logic [31:0]        wide;
  logic               found;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (i >= int'(ptr));
    end
    // Nothing at or above ptr means the search wraps to the unmasked vector.
    sel = (mode && |(req & hi_mask)) ? (req & hi_mask) : req;

    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel[i] && !found) begin
        win[i] = 1'b1;
        found  = 1'b1;
      end
    end

    wide               = '0;
    wide[NUM_REQ-1:0]  = win;
    win_idx            = IDX_W'(onehot2idx(wide));
    any                = |req;
  end

endmodule

// File: rtl/mutex_arbiter_n.sv
// N-way mutual-exclusion arbiter: registered one-hot grant held until release, one dead cycle between owners.
// Latency: SYNC_STAGES+1 edges request-to-grant from idle; grant drops one edge after release/revocation.
// Backpressure: requesters hold req until served; optional MAX_HOLD revokes a hog when others wait.
module mutex_arbiter_n #(
  parameter int NUM_REQ     = 5,
  parameter int MODE        = 1,
  parameter int MAX_HOLD    = 0,
  parameter int SYNC_STAGES = 2,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_vld,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               preempt
);
  import arb_pkg::*;

  localparam int HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

  logic [NUM_REQ-1:0] req_s;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign req_s = req;
    end else begin : g_sync
      logic [NUM_REQ-1:0] sync_q [SYNC_STAGES];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
          sync_q[0] <= req;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign req_s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  arb_state_e         state;
  logic [IDX_W-1:0]   ptr;
  logic [HC_W-1:0]    hold_cnt;
  logic [NUM_REQ-1:0] win;
  logic [IDX_W-1:0]   win_idx;
  logic               any;
  logic               owner_req;
  logic               others;
  logic               revoke;

  arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req_s),
    .ptr     (ptr),
    .mode    (MODE == ARB_RR),
    .win     (win),
    .win_idx (win_idx),
    .any     (any)
  );

  assign owner_req = |(req_s & grant);
  assign others    = |(req_s & ~grant);
  assign revoke    = (MAX_HOLD > 0) && owner_req && (hold_cnt == HOLD_MAX) && others;
  assign grant_vld = |grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      grant     <= '0;
      grant_idx <= '0;
      ptr       <= '0;
      hold_cnt  <= '0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        ST_BUSY: begin
          if (!owner_req || revoke) begin
            grant     <= '0;
            grant_idx <= '0;
            preempt   <= revoke;
            state     <= ST_GAP;
          end else if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + HC_W'(1);
          end
        end
        default: begin
          // IDLE and the single GAP cycle both arbitrate the same way.
          if (any) begin
            grant     <= win;
            grant_idx <= win_idx;
            hold_cnt  <= '0;
            state     <= ST_BUSY;
            if (MODE == ARB_RR) begin
              ptr <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mutex_arbiter_n.sv
// Four arbiter configurations driven by one request bus, checked each cycle against a behavioural model.
module tb_mutex_arbiter_n;
  localparam int N = 5;

  // Per-instance configuration: A=RR/unlimited, B=RR/hold4, C=fixed/hold4, D=RR/hold4/2-stage sync.
  localparam int C_MODE [4] = '{1, 1, 0, 1};
  localparam int C_HOLD [4] = '{0, 4, 4, 4};
  localparam int C_SYNC [4] = '{0, 0, 0, 2};

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;

  logic [N-1:0] g  [4];
  logic         gv [4];
  logic [2:0]   gi [4];
  logic         pe [4];

  always #5 clk = ~clk;

  mutex_arbiter_n #(.NUM_REQ(N), .MODE(1), .MAX_HOLD(0), .SYNC_STAGES(0)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(g[0]), .grant_vld(gv[0]), .grant_idx(gi[0]), .preempt(pe[0]));
  mutex_arbiter_n #(.NUM_REQ(N), .MODE(1), .MAX_HOLD(4), .SYNC_STAGES(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(g[1]), .grant_vld(gv[1]), .grant_idx(gi[1]), .preempt(pe[1]));
  mutex_arbiter_n #(.NUM_REQ(N), .MODE(0), .MAX_HOLD(4), .SYNC_STAGES(0)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(g[2]), .grant_vld(gv[2]), .grant_idx(gi[2]), .preempt(pe[2]));
  mutex_arbiter_n #(.NUM_REQ(N), .MODE(1), .MAX_HOLD(4), .SYNC_STAGES(2)) u_d (
    .clk(clk), .rst_n(rst_n), .req(req), .grant(g[3]), .grant_vld(gv[3]), .grant_idx(gi[3]), .preempt(pe[3]));

  int vecs = 0;
  int errs = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: who owns the resource, for how many edges, and whose turn is next.
  logic [N-1:0] rh [4];
  bit           m_busy [4];
  int           m_owner [4];
  int           m_held [4];
  int           m_ptr [4];
  bit           m_pre [4];

  function automatic void model_step(input int k, input logic [N-1:0] rs);
    int  j;
    bit  found;
    m_pre[k] = 1'b0;
    if (m_busy[k]) begin
      if (!rs[m_owner[k]]) begin
        m_busy[k] = 1'b0;
      end else if (C_HOLD[k] > 0 && m_held[k] >= C_HOLD[k] && (rs & ~(N'(1) << m_owner[k])) != 0) begin
        m_busy[k] = 1'b0;
        m_pre[k]  = 1'b1;
      end else begin
        m_held[k]++;
      end
    end else if (rs != 0) begin
      found = 1'b0;
      for (int t = 0; t < N; t++) begin
        j = (C_MODE[k] == 1) ? (m_ptr[k] + t) % N : t;
        if (!found && rs[j]) begin
          found      = 1'b1;
          m_owner[k] = j;
        end
      end
      m_busy[k] = 1'b1;
      m_held[k] = 0;
      if (C_MODE[k] == 1) m_ptr[k] = (m_owner[k] + 1) % N;
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) begin
          m_busy[k] = 1'b0; m_owner[k] = 0; m_held[k] = 0; m_ptr[k] = 0; m_pre[k] = 1'b0;
          rh[k] = '0;
        end
      end else begin
        for (int j = 3; j > 0; j--) rh[j] = rh[j-1];
        rh[0] = req;
        for (int k = 0; k < 4; k++) model_step(k, rh[C_SYNC[k]]);
      end
    end
  end

  // Continuous checker on the falling edge.
  logic [N-1:0] prev_g [4];
  initial begin
    for (int k = 0; k < 4; k++) prev_g[k] = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        cmp($sformatf("grant[%0d]", k), int'(g[k]), m_busy[k] ? int'(N'(1) << m_owner[k]) : 0);
        cmp($sformatf("grant_vld[%0d]", k), int'(gv[k]), int'(m_busy[k]));
        cmp($sformatf("grant_idx[%0d]", k), int'(gi[k]), m_busy[k] ? m_owner[k] : 0);
        cmp($sformatf("preempt[%0d]", k), int'(pe[k]), int'(m_pre[k]));
        cmp($sformatf("onehot[%0d]", k), int'($countones(g[k]) <= 1), 1);
        cmp($sformatf("direct_handover[%0d]", k),
            int'(prev_g[k] != 0 && g[k] != 0 && prev_g[k] != g[k]), 0);
        prev_g[k] = g[k];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  int q_seq [$];
  int q_run [$];
  int exp_seq [6] = '{1, 2, 4, 8, 16, 1};
  int run, npre, nbad, ngr, nok;
  logic [N-1:0] last;

  initial begin
    // Reset with every requester asserting.
    req = '1;
    tick(3);
    @(negedge clk);
    cmp("reset_grant", int'(g[0]), 0);
    cmp("reset_vld", int'(gv[0]), 0);
    cmp("reset_idx", int'(gi[0]), 0);
    cmp("reset_preempt", int'(pe[0]), 0);
    cmp("reset_grant_sync", int'(g[3]), 0);
    rst_n = 1'b1;
    tick(1);
    @(negedge clk);
    cmp("first_grant", int'(g[0]), 5'b00001);

    // Mutex hold with unlimited hold time.
    req = '0;
    tick(3);
    req = 5'b00001;
    tick(1);
    req = 5'b00011;
    tick(3);
    @(negedge clk);
    cmp("hold_owner", int'(g[0]), 5'b00001);
    req = 5'b00010;
    tick(1);
    @(negedge clk);
    cmp("gap_cycle", int'(g[0]), 0);
    tick(1);
    @(negedge clk);
    cmp("next_owner", int'(g[0]), 5'b00010);
    cmp("next_owner_idx", int'(gi[0]), 1);

    // Round-robin revocation with everyone waiting.
    req = '0;
    rst_pulse();
    req = '1;
    tick(1);
    run = 0; npre = 0; last = '0;
    for (int c = 0; c < 35; c++) begin
      @(negedge clk);
      if (pe[1]) npre++;
      if (g[1] != 0) begin
        if (g[1] != last) begin
          q_seq.push_back(int'(g[1]));
          if (run > 0) q_run.push_back(run);
          run = 0;
        end
        run++;
      end
      last = g[1];
    end
    q_run.push_back(run);
    cmp("rr_grant_count", q_seq.size(), 6);
    for (int i = 0; i < 6; i++) cmp($sformatf("rr_seq[%0d]", i), q_seq[i], exp_seq[i]);
    for (int i = 0; i < 6; i++) cmp($sformatf("rr_len[%0d]", i), q_run[i], 5);
    cmp("rr_preempts", npre, 5);

    // Fixed priority: requester 1 keeps winning after each revocation.
    req = '0;
    rst_pulse();
    req = 5'b10110;
    tick(1);
    nbad = 0; ngr = 0; npre = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (g[2] != 0 && g[2] != 5'b00010) nbad++;
      if (g[2] != 0) ngr++;
      if (pe[2]) npre++;
    end
    cmp("fixed_wrong_winner", nbad, 0);
    cmp("fixed_grant_cycles", ngr, 25);
    cmp("fixed_preempts", npre, 5);

    // Lone owner is never revoked.
    req = '0;
    rst_pulse();
    req = 5'b01000;
    tick(1);
    nok = 0; npre = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (g[1] == 5'b01000) nok++;
      if (pe[1]) npre++;
    end
    cmp("lone_held", nok, 20);
    cmp("lone_preempts", npre, 0);

    // Synchroniser latency, then asynchronous reset in the middle of ownership.
    req = '0;
    rst_pulse();
    tick(2);
    req = 5'b01000;
    tick(1);
    @(negedge clk);
    cmp("sync_k", int'(g[3]), 0);
    tick(1);
    @(negedge clk);
    cmp("sync_k1", int'(g[3]), 0);
    tick(1);
    @(negedge clk);
    cmp("sync_k2", int'(g[3]), 5'b01000);
    tick(2);
    @(negedge clk);
    cmp("busy_before_reset", int'(g[3]), 5'b01000);
    #2 rst_n = 1'b0;
    #1;
    cmp("async_reset_grant", int'(g[3]), 0);
    cmp("async_reset_vld", int'(gv[3]), 0);
    tick(1);
    rst_n = 1'b1;

    // Random bursty requests with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      req   = req ^ N'($urandom & $urandom & $urandom);
      rst_n = ($urandom_range(0, 399) != 0);
      tick(1);
    end
    rst_n = 1'b1;
    tick(2);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/mutex_arbiter_n.md
# mutex_arbiter_n

Synchronous, parametrised N-way mutual-exclusion arbiter. It is the clocked successor to the 5-input mutex arbiter. Each requester holds its request for as long as it needs a shared resource. The block issues at most one registered one-hot grant, holds it until the owner releases, and inserts a one-cycle dead time between owners. It adds selectable fixed or round-robin priority, optional input synchronisers and optional forced revocation after a hold limit.

## Interface
- NUM_REQ, 5, number of requesters (2..32)
- MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
- MAX_HOLD, 0, maximum grant cycles before revocation when others wait; 0 = unlimited
- SYNC_STAGES, 2, flops per req bit for asynchronous requesters (0, 2 or 3)
- IDX_W, $clog2(NUM_REQ), derived; not overridden
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  level requests; bit i high = requester i wants or holds the resource
- grant  out  NUM_REQ  registered one-hot grant, or all-zero
- grant_vld  out  1  OR of grant
- grant_idx  out  IDX_W  index of the owner while grant_vld = 1, else 0
- preempt  out  1  one-cycle pulse on the cycle a grant is revoked by MAX_HOLD

## Operation
- req_s is req after SYNC_STAGES flops (passthrough when 0). All decisions use req_s.
- State machine IDLE / BUSY / GAP.
  - IDLE: if req_s != 0, pick a winner, load grant and go to BUSY; otherwise stay.
  - BUSY: the grant is held while req_s[owner] = 1; other requests are ignored.
    - On release (req_s[owner] = 0): grant clears and the state goes to GAP.
    - On revocation (see MAX_HOLD below): grant clears, preempt = 1 and the state goes to GAP.
  - GAP: exactly one cycle with grant = 0. Then arbitrate like IDLE: go to BUSY if any request, else IDLE.
- Picker, MODE = 1: search upward from ptr with wrap-around; the first set bit wins. Then ptr <= winner+1, and (NUM_REQ-1)+1 wraps to 0.
- Picker, MODE = 0: the lowest set index wins; ptr is unused.
- MAX_HOLD > 0: hold_cnt clears on grant and increments each BUSY cycle, saturating at MAX_HOLD.
  - Revocation fires when hold_cnt = MAX_HOLD and any other req_s bit is set.
  - If the owner is alone, the grant is kept with no preempt.
  - A revoked owner that keeps req high re-competes. In RR mode it has the lowest priority because of ptr.
- Release and revocation in the same cycle count as a release: preempt stays 0.
- Mutual exclusion: popcount(grant) <= 1 always, and no cycle hands grant directly from one owner to another.

## Timing
- Reset (async assert, sync-clean deassert) gives:
  - grant = 0, grant_vld = 0, grant_idx = 0, preempt = 0
  - state = IDLE, ptr = 0, hold_cnt = 0
  - synchroniser flops = 0
- Reset during BUSY clears grant immediately, without waiting for a clock edge.
- Request-to-grant latency from IDLE: req set before edge k gives grant high after edge k+SYNC_STAGES.
- Release-to-next-grant: owner req dropped before edge k gives:
  - grant = 0 after edge k+SYNC_STAGES (GAP)
  - new grant after edge k+SYNC_STAGES+1
- Revocation: grant drops after the edge at which hold_cnt = MAX_HOLD with others pending. preempt is high for that same cycle only.
- Grant length under revocation is MAX_HOLD+1 cycles.
- grant_idx and grant_vld change on the same edges as grant.

## Structure
- Package arb_pkg holds:
  - ARB_FIXED = 0 and ARB_RR = 1
  - the state enum (ST_IDLE, ST_BUSY, ST_GAP)
  - a onehot-to-index function
- Sub-module arb_rr_pick: combinational masked priority picker.
  - Inputs: req vector, ptr, mode.
  - Outputs: one-hot winner, winner index, any.
  - Implemented as a double-width or masked search.
- The top level holds the synchronisers, FSM, ptr, hold_cnt and output registers.

## Test plan
All scenarios use NUM_REQ = 5 and SYNC_STAGES = 0 unless stated.
- Reset: rst_n = 0 with req = 5'b11111 -> grant = 0, grant_vld = 0, grant_idx = 0, preempt = 0. First grant after release = 5'b00001.
- Mutex hold (MAX_HOLD = 0): req 5'b00001, then 5'b00011 -> grant stays 5'b00001. Drop req[0] -> one cycle of 5'b00000, then 5'b00010, grant_idx = 1.
- Round-robin revocation (MAX_HOLD = 4, MODE = 1): req = 5'b11111 held.
  - Grant sequence is 00001, 00010, 00100, 01000, 10000, 00001, each held 5 cycles with a 1-cycle gap.
  - preempt pulses once per hand-over.
- Fixed priority (MODE = 0, MAX_HOLD = 4): req = 5'b10110 held -> after each revocation, grant returns to 5'b00010. Bits 2 and 4 never win.
- Lone owner (MAX_HOLD = 4): req = 5'b01000 for 20 cycles -> grant = 5'b01000 throughout, preempt never asserted.
- Synchroniser latency and async reset (SYNC_STAGES = 2):
  - req[3] set before edge k -> grant = 5'b01000 after edge k+2.
  - rst_n low mid-BUSY -> grant = 0 before the next clk edge.
  - A scoreboard asserts popcount(grant) <= 1 every cycle.
